// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/cpu_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect handling.
// Optional feature: define CPU_FETCH_MISALIGN_CHECK_EN to reject misaligned redirect targets.
module cpu_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_resolve,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misaligned_target
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  fetch_addr, fetch_addr_next;
  logic         load_inst;
  logic         redirect_raw;
  logic         redirect;
  logic [31:0]  redir_target;

  assign redirect_raw = jump | (branch_resolve & branch_taken);

`ifdef CPU_FETCH_MISALIGN_CHECK_EN
  logic target_bad;

  assign target_bad   = |target[1:0];
  assign redirect     = redirect_raw & ~target_bad;
  assign redir_target = target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned_target <= 1'b0;
    else     misaligned_target <= redirect_raw & target_bad;
  end
`else
  logic unused_target_bits;

  assign unused_target_bits = ^target[1:0];
  assign redirect           = redirect_raw;
  assign redir_target       = {target[31:2], 2'b00};
  assign misaligned_target  = 1'b0;
`endif

  assign imem_addr = fetch_addr;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    fetch_addr_next = fetch_addr;
    load_inst       = 1'b0;
    imem_req        = 1'b0;
    inst_valid      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_next = redir_target;
          // An ack alongside a redirect completes the stale request, so the
          // new target can be issued immediately instead of via DISCARD.
          if (imem_ack) fetch_addr_next = redir_target;
          else          state_next      = DISCARD;
        end else if (imem_ack) begin
          load_inst  = 1'b1;
          pc_next    = pc + PC_STEP;
          state_next = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (redirect) begin
          pc_next         = redir_target;
          fetch_addr_next = redir_target;
          state_next      = FETCH;
        end else if (inst_ready) begin
          fetch_addr_next = pc;
          state_next      = FETCH;
        end
      end
      DISCARD: begin
        imem_req = 1'b1;
        if (redirect) pc_next = redir_target;
        if (imem_ack) begin
          fetch_addr_next = pc_next;
          state_next      = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      fetch_addr <= fetch_addr_next;
      if (load_inst) begin
        inst    <= imem_rdata;
        inst_pc <= fetch_addr;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Testbench for cpu_fetch_unit: transaction-level model plus directed and random stimulus.
module tb_cpu_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_resolve, branch_taken, jump;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_ready;
  logic        misaligned_target;

  int checks   = 0;
  int failures = 0;

  cpu_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_resolve   (branch_resolve),
    .branch_taken     (branch_taken),
    .jump             (jump),
    .target           (target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .inst_valid       (inst_valid),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_ready       (inst_ready),
    .misaligned_target(misaligned_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an instruction is either being presented (m_hold) or a request is
  // outstanding; m_disc marks an outstanding request whose data must be dropped.
  bit          m_hold = 1'b0, m_disc = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pc = RPC, m_req = RPC, m_inst = '0, m_ipc = '0;

  initial forever begin
    logic        want, take;
    logic [31:0] t;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_hold = 1'b0; m_disc = 1'b0; m_mis = 1'b0;
      m_pc = RPC; m_req = RPC; m_inst = '0; m_ipc = '0;
    end else begin
      want = jump | (branch_resolve & branch_taken);
`ifdef CPU_FETCH_MISALIGN_CHECK_EN
      t     = target;
      take  = want && (t[1:0] == 2'b00);
      m_mis = want && (t[1:0] != 2'b00);
`else
      t     = target & 32'hFFFF_FFFC;
      take  = want;
      m_mis = 1'b0;
`endif
      if (m_hold) begin
        if (take) begin
          m_pc = t; m_req = t; m_hold = 1'b0;
        end else if (inst_ready) begin
          m_req = m_pc; m_hold = 1'b0;
        end
      end else if (imem_ack) begin
        if (take) m_pc = t;
        if (m_disc) begin
          m_disc = 1'b0; m_req = m_pc;
        end else if (take) begin
          m_req = t;
        end else begin
          m_inst = mem_word(m_req); m_ipc = m_req; m_pc = m_pc + 32'd4; m_hold = 1'b1;
        end
      end else if (take) begin
        m_pc = t; m_disc = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("inst_valid", 32'(inst_valid), 32'(m_hold));
    chk("imem_req", 32'(imem_req), 32'(!m_hold));
    if (!m_hold) chk("imem_addr", imem_addr, m_req);
    else begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
    end
    chk("misaligned_target", 32'(misaligned_target), 32'(m_mis));
  end

  int ack_lat = 0;
  int wcnt    = 0;
  bit rnd_ack = 1'b0;

  task automatic cyc(input logic br, input logic bt, input logic jmp,
                     input logic [31:0] tgt, input logic rdy);
    branch_resolve = br;
    branch_taken   = bt;
    jump           = jmp;
    target         = tgt;
    inst_ready     = rdy;
    if (!m_hold) begin
      if (rnd_ack) imem_ack = 1'($urandom_range(0, 1));
      else         imem_ack = (wcnt >= ack_lat);
      if (imem_ack) wcnt = 0;
      else          wcnt++;
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
    imem_rdata = imem_ack ? mem_word(m_req) : $urandom;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] old_addr;
    rst = 1'b1;
    branch_resolve = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    target = '0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_mis", 32'(misaligned_target), 32'd0);
    rst = 1'b0;

    // Zero-latency memory, decode always ready
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, 1);
      chk("seq_valid", 32'(inst_valid), 32'd1);
      chk("seq_pc", inst_pc, 32'(i * 4));
      cyc(0, 0, 0, '0, 1);
      chk("seq_gap", 32'(inst_valid), 32'd0);
    end

    // Slow memory, stalled decode
    ack_lat = 3;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, 0);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h0C);
    end
    cyc(0, 0, 0, '0, 0);
    chk("slow_pc", inst_pc, 32'h0C);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, '0, 0);
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_pc", inst_pc, 32'h0C);
      chk("hold_inst", inst, mem_word(32'h0C));
      chk("hold_noreq", 32'(imem_req), 32'd0);
    end
    cyc(0, 0, 0, '0, 1);
    chk("after_hold_addr", imem_addr, 32'h10);

    // Redirect while waiting for ack
    cyc(0, 0, 1, 32'h100, 1);
    chk("disc_addr", imem_addr, 32'h10);
    for (int k = 0; k < 8 && !(imem_req && imem_addr == 32'h100); k++) cyc(0, 0, 0, '0, 1);
    chk("redir_addr", imem_addr, 32'h100);
    for (int k = 0; k < 8 && !inst_valid; k++) cyc(0, 0, 0, '0, 1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_inst", inst, mem_word(32'h100));

    // Branch redirect from HOLD wins over inst_ready
    ack_lat = 0;
    cyc(0, 0, 1, 32'h8, 1);
    cyc(0, 0, 0, '0, 0);
    chk("br_hold_pc", inst_pc, 32'h8);
    cyc(1, 1, 0, 32'h40, 1);
    chk("br_drop", 32'(inst_valid), 32'd0);
    chk("br_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, '0, 0);
    chk("br_pc", inst_pc, 32'h40);
    cyc(0, 1, 0, 32'h200, 1);
    chk("nobr_addr", imem_addr, 32'h44);

    // Misaligned jump target
    cyc(0, 0, 1, 32'h102, 0);
`ifdef CPU_FETCH_MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(misaligned_target), 32'd1);
    chk("mis_seq_pc", inst_pc, 32'h44);
    cyc(0, 0, 0, '0, 1);
    chk("mis_clear", 32'(misaligned_target), 32'd0);
    chk("mis_next_addr", imem_addr, 32'h48);
    old_addr = 32'h48;
`else
    chk("mis_tied", 32'(misaligned_target), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
    old_addr = 32'h100;
`endif

    // Asynchronous reset in the middle of a discarded request
    ack_lat = 5;
    cyc(0, 0, 1, 32'h300, 0);
    chk("pre_rst_addr", imem_addr, old_addr);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd1);
    chk("arst_addr", imem_addr, RPC);
    chk("arst_mis", 32'(misaligned_target), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    imem_ack = 1'b0; jump = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    wcnt = 0;
    ack_lat = 2;
    chk("post_rst_addr", imem_addr, RPC);
    for (int k = 0; k < 8 && !inst_valid; k++) cyc(0, 0, 0, '0, 1);
    chk("post_rst_pc", inst_pc, RPC);

    // Random traffic
    rnd_ack = 1'b1;
    repeat (3000) begin
      logic [31:0] tgt;
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      cyc(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0), tgt, 1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
